// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one single-port synchronous memory
// Data wins by default; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_stall,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_stall,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_I    = 2'd1,
        G_D    = 2'd2
    } gnt_t;

    gnt_t              gnt_d, gnt_q;
    logic              we_d, we_q;
    logic [3:0]        cnt_d, cnt_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic [DATA_W-1:0] i_rdata_d, i_rdata_q;
    logic [DATA_W-1:0] d_rdata_d, d_rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_q     <= G_NONE;
            we_q      <= 1'b0;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        gnt_d     = G_NONE;
        we_d      = 1'b0;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = addr_q;
        m_wdata   = wdata_q;

        // Nothing is granted while reset is asserted, so both stalls mirror the requests.
        if (!reset) begin
            if (i_req && (!d_req || cnt_q >= SMAX)) begin
                gnt_d = G_I;
            end else if (d_req) begin
                gnt_d = G_D;
            end
        end

        case (gnt_d)
            G_I: begin
                m_en   = 1'b1;
                m_addr = i_addr;
                addr_d = i_addr;
            end
            G_D: begin
                m_en    = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                addr_d  = d_addr;
                wdata_d = d_wdata;
                we_d    = d_we;
            end
            default: ;
        endcase

        if (gnt_d == G_I || !i_req) begin
            cnt_d = 4'd0;
        end else if (gnt_d == G_D && cnt_q < SMAX) begin
            cnt_d = cnt_q + 4'd1;
        end

        // Capture read data so the outputs hold their last value between valids.
        if (gnt_q == G_I) begin
            i_rdata_d = m_rdata;
        end
        if (gnt_q == G_D && !we_q) begin
            d_rdata_d = m_rdata;
        end
    end

    assign i_stall    = i_req && (gnt_d != G_I);
    assign d_stall    = d_req && (gnt_d != G_D);
    assign i_valid    = (gnt_q == G_I);
    assign d_valid    = (gnt_q == G_D);
    assign i_rdata    = (gnt_q == G_I) ? m_rdata : i_rdata_q;
    assign d_rdata    = (gnt_q == G_D && !we_q) ? m_rdata : d_rdata_q;
    assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_stall;
    logic        i_valid;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_stall;
    logic        d_valid;
    logic [15:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic [3:0]  starve_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_stall(i_stall), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .starve_cnt(starve_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write-first single-port memory; mem[a] = {a,a} except two preloaded words.
    logic [15:0] mem [256];
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = {a[7:0], a[7:0]};
        mem[8'h02] = 16'h5A5A;
        mem[8'h10] = 16'h00AB;
        m_rdata = 16'h0000;
        forever begin
            @(posedge clock);
            if (m_en) begin
                if (m_we) begin
                    mem[m_addr] = m_wdata;
                    m_rdata <= m_wdata;
                end else begin
                    m_rdata <= mem[m_addr];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ir, input logic [7:0] ia,
                         input logic dr, input logic dw, input logic [7:0] da,
                         input logic [15:0] dd);
        @(negedge clock);
        reset = rst; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
    endtask

    int exp_cnt [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        reset = 1'b1; i_req = 1'b1; i_addr = 8'h00;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;

        // Reset held two cycles with both requesting
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 8'h02, 1, 0, 8'h10, 16'h0);
            chk("rst_m_en", m_en, 0);
            chk("rst_i_stall", i_stall, 1);
            chk("rst_d_stall", d_stall, 1);
            chk("rst_i_valid", i_valid, 0);
            chk("rst_d_valid", d_valid, 0);
            chk("rst_starve", starve_cnt, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end

        // Lone fetch
        drive(0, 1, 8'h02, 0, 0, 8'h00, 16'h0);
        chk("fetch_m_en", m_en, 1);
        chk("fetch_m_we", m_we, 0);
        chk("fetch_m_addr", m_addr, 8'h02);
        chk("fetch_i_stall", i_stall, 0);
        chk("fetch_i_valid0", i_valid, 0);
        drive(0, 0, 8'h02, 0, 0, 8'h00, 16'h0);
        chk("fetch_i_valid", i_valid, 1);
        chk("fetch_i_rdata", i_rdata, 16'h5A5A);
        chk("fetch_i_stall1", i_stall, 0);
        chk("idle_m_en", m_en, 0);
        chk("idle_m_addr_hold", m_addr, 8'h02);

        // Conflict: load wins, fetch follows
        drive(0, 1, 8'h03, 1, 0, 8'h10, 16'h0);
        chk("conf_m_addr", m_addr, 8'h10);
        chk("conf_i_stall", i_stall, 1);
        chk("conf_d_stall", d_stall, 0);
        drive(0, 1, 8'h03, 0, 0, 8'h10, 16'h0);
        chk("conf_d_valid", d_valid, 1);
        chk("conf_d_rdata", d_rdata, 16'h00AB);
        chk("conf_starve1", starve_cnt, 1);
        chk("conf_i_stall_off", i_stall, 0);
        chk("conf_fetch_addr", m_addr, 8'h03);
        drive(0, 0, 8'h03, 0, 0, 8'h10, 16'h0);
        chk("conf_i_valid", i_valid, 1);
        chk("conf_i_rdata", i_rdata, 16'h0303);
        chk("conf_i_rdata_hold_d", d_rdata, 16'h00AB);
        chk("conf_starve_clr", starve_cnt, 0);

        // Starvation: both held six cycles
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 8'h04, 1, 0, 8'h10, 16'h0);
            chk($sformatf("starve_cnt_%0d", k), starve_cnt, exp_cnt[k]);
            chk($sformatf("starve_i_stall_%0d", k), i_stall, (k == 4) ? 0 : 1);
            chk($sformatf("starve_d_stall_%0d", k), d_stall, (k == 4) ? 1 : 0);
            chk($sformatf("starve_m_addr_%0d", k), m_addr, (k == 4) ? 8'h04 : 8'h10);
            chk($sformatf("starve_d_valid_%0d", k), d_valid, (k >= 1 && k <= 4) ? 1 : 0);
            chk($sformatf("starve_i_valid_%0d", k), i_valid, (k == 5) ? 1 : 0);
        end
        chk("starve_i_rdata", i_rdata, 16'h0404);
        drive(0, 0, 8'h04, 0, 0, 8'h10, 16'h0);
        chk("starve_tail_d_valid", d_valid, 1);
        chk("starve_tail_cnt", starve_cnt, 1);

        // Store then load to the same address
        drive(0, 0, 8'h00, 1, 1, 8'h20, 16'h3C00);
        chk("st_m_en", m_en, 1);
        chk("st_m_we", m_we, 1);
        chk("st_m_addr", m_addr, 8'h20);
        chk("st_m_wdata", m_wdata, 16'h3C00);
        chk("st_cnt_clr", starve_cnt, 0);
        drive(0, 0, 8'h00, 1, 0, 8'h20, 16'h0000);
        chk("st_ack_valid", d_valid, 1);
        chk("st_ack_rdata_hold", d_rdata, 16'h00AB);
        chk("ld_m_we", m_we, 0);
        drive(0, 0, 8'h00, 0, 0, 8'h20, 16'h0000);
        chk("ld_d_valid", d_valid, 1);
        chk("ld_d_rdata", d_rdata, 16'h3C00);
        chk("ld_idle_m_we", m_we, 0);
        chk("ld_idle_wdata_hold", m_wdata, 16'h0000);

        // Reset asserted in the cycle a fetch is requested
        drive(1, 1, 8'h02, 0, 0, 8'h00, 16'h0);
        chk("mrst_m_en", m_en, 0);
        chk("mrst_i_stall", i_stall, 1);
        drive(0, 0, 8'h02, 0, 0, 8'h00, 16'h0);
        chk("mrst_i_valid", i_valid, 0);
        chk("mrst_d_valid", d_valid, 0);
        chk("mrst_i_rdata", i_rdata, 0);
        chk("mrst_d_rdata", d_rdata, 0);
        chk("mrst_starve", starve_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
